// File: rtl/bcd_xs3_seq_if.sv
// Request/result bundle for the BCD-to-excess-3 sequencer: job request in, result plus valid/ack out.
// The requester side uses the master modport; the sequencer uses the slave modport.
interface bcd_xs3_seq_if #(
  parameter int NDIG = 4
);
  logic                in_start;
  logic [4*NDIG-1:0]   in_bcd;
  logic                in_ack;
  logic                out_busy;
  logic                out_valid;
  logic [4*NDIG-1:0]   out_xs3;
  logic                out_err;

  modport master (
    output in_start, in_bcd, in_ack,
    input  out_busy, out_valid, out_xs3, out_err
  );

  modport slave (
    input  in_start, in_bcd, in_ack,
    output out_busy, out_valid, out_xs3, out_err
  );
endinterface

// File: rtl/bcd_xs3_seq.sv
// Converts a packed NDIG-digit BCD word to excess-3 through one shared digit converter, LSD first.
// Latency: out_valid rises NDIG edges after the accepting edge (earlier on an invalid digit when BCD_XS3_ERR_ABORT_EN is defined).
// Backpressure: the result is held in DONE until in_ack; in_start is only sampled in IDLE, with no queueing.
module bcd_xs3_seq #(
  parameter int NDIG = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  bcd_xs3_seq_if.slave bus
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]          state;
  logic [4*NDIG-1:0]   operand;
  logic [IW-1:0]       idx;
  logic [4*NDIG-1:0]   xs3;
  logic                err;

  logic [3:0]          dig_bcd;
  logic [3:0]          dig_xs3;
  logic                dig_bad;
  logic                dig_last;

  // The shared digit converter: arithmetic +3, truncated, valid for any nibble.
  always_comb begin
    dig_bcd  = operand[{idx, 2'b00} +: 4];
    dig_xs3  = dig_bcd + 4'd3;
    dig_bad  = (dig_bcd > 4'd9);
    dig_last = (idx == IW'(NDIG - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      operand <= '0;
      idx     <= '0;
      xs3     <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_start) begin
            operand <= bus.in_bcd;
            xs3     <= '0;
            err     <= 1'b0;
            idx     <= '0;
            state   <= S_CONVERT;
          end
        end
        S_CONVERT: begin
`ifdef BCD_XS3_ERR_ABORT_EN
          if (dig_bad) begin
            // Abort: the offending slot and all later slots remain zero.
            xs3[{idx, 2'b00} +: 4] <= 4'h0;
            err                    <= 1'b1;
            idx                    <= '0;
            state                  <= S_DONE;
          end else begin
            xs3[{idx, 2'b00} +: 4] <= dig_xs3;
            if (dig_last) begin
              idx   <= '0;
              state <= S_DONE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
`else
          xs3[{idx, 2'b00} +: 4] <= dig_xs3;
          if (dig_bad) begin
            err <= 1'b1;
          end
          if (dig_last) begin
            idx   <= '0;
            state <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
`endif
        end
        S_DONE: begin
          if (bus.in_ack) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_busy  = (state == S_CONVERT) || (state == S_DONE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_xs3   = xs3;
  assign bus.out_err   = err;

endmodule

// File: tb/tb_bcd_xs3_seq.sv
// Directed bench for bcd_xs3_seq (NDIG=4); expectations follow BCD_XS3_ERR_ABORT_EN when it is defined.
module tb_bcd_xs3_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bcd_xs3_seq_if #(.NDIG(4)) bus ();

  bcd_xs3_seq #(.NDIG(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle start; returns just after the accepting edge.
  task automatic start_job(input logic [15:0] bcd);
    bus.in_bcd   = bcd;
    bus.in_start = 1'b1;
    step();
    bus.in_start = 1'b0;
  endtask

  // Edges until out_valid, bounded so a dead DUT shows up as a latency mismatch.
  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 30) begin
      step();
      n++;
    end
  endtask

  task automatic do_ack();
    bus.in_ack = 1'b1;
    step();
    bus.in_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #22;
    checks++; if (bus.out_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.out_busy); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_xs3 !== 16'h0000) begin failures++; $display("FAIL reset_xs3 got=%h exp=0000", bus.out_xs3); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.out_err); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    int n;
    start_job(16'h1234);
    checks++; if (bus.out_busy !== 1'b1) begin failures++; $display("FAIL basic_busy_after_accept got=%b exp=1", bus.out_busy); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_valid_early got=%b exp=0", bus.out_valid); end
    wait_valid(n);
    checks++; if (n !== 4) begin failures++; $display("FAIL basic_latency got=%0d exp=4", n); end
    checks++; if (bus.out_xs3 !== 16'h4567) begin failures++; $display("FAIL basic_xs3 got=%h exp=4567", bus.out_xs3); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", bus.out_err); end
    do_ack();
    checks++; if (bus.out_busy !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_ack_idle got=busy%b/valid%b exp=0/0", bus.out_busy, bus.out_valid); end
    checks++; if (bus.out_xs3 !== 16'h4567) begin failures++; $display("FAIL basic_xs3_retained got=%h exp=4567", bus.out_xs3); end
  endtask

  task automatic test_invalid();
    int n;
    start_job(16'h12A4);
    wait_valid(n);
`ifdef BCD_XS3_ERR_ABORT_EN
    checks++; if (n !== 2) begin failures++; $display("FAIL inv1_latency got=%0d exp=2", n); end
    checks++; if (bus.out_xs3 !== 16'h0007) begin failures++; $display("FAIL inv1_xs3 got=%h exp=0007", bus.out_xs3); end
`else
    checks++; if (n !== 4) begin failures++; $display("FAIL inv1_latency got=%0d exp=4", n); end
    checks++; if (bus.out_xs3 !== 16'h45D7) begin failures++; $display("FAIL inv1_xs3 got=%h exp=45d7", bus.out_xs3); end
`endif
    checks++; if (bus.out_err !== 1'b1) begin failures++; $display("FAIL inv1_err got=%b exp=1", bus.out_err); end
    do_ack();
    start_job(16'hFDA0);
    wait_valid(n);
`ifdef BCD_XS3_ERR_ABORT_EN
    checks++; if (bus.out_xs3 !== 16'h0003) begin failures++; $display("FAIL inv2_xs3 got=%h exp=0003", bus.out_xs3); end
`else
    checks++; if (bus.out_xs3 !== 16'h20D3) begin failures++; $display("FAIL inv2_xs3 got=%h exp=20d3", bus.out_xs3); end
`endif
    checks++; if (bus.out_err !== 1'b1) begin failures++; $display("FAIL inv2_err got=%b exp=1", bus.out_err); end
    do_ack();
  endtask

  task automatic test_patterns();
    int n;
    start_job(16'h9090);
    wait_valid(n);
    checks++; if (bus.out_xs3 !== 16'hC3C3) begin failures++; $display("FAIL pat9090_xs3 got=%h exp=c3c3", bus.out_xs3); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL pat9090_err got=%b exp=0", bus.out_err); end
    do_ack();
    start_job(16'h0000);
    wait_valid(n);
    checks++; if (n !== 4) begin failures++; $display("FAIL pat0000_latency got=%0d exp=4", n); end
    checks++; if (bus.out_xs3 !== 16'h3333) begin failures++; $display("FAIL pat0000_xs3 got=%h exp=3333", bus.out_xs3); end
    do_ack();
  endtask

  task automatic test_ignore_start();
    int n;
    start_job(16'h1234);
    bus.in_start = 1'b1;
    bus.in_bcd   = 16'h5555;
    step();
    bus.in_bcd   = 16'h9999;
    step();
    bus.in_start = 1'b0;
    wait_valid(n);
    checks++; if (n + 2 !== 4) begin failures++; $display("FAIL ign_latency got=%0d exp=4", n + 2); end
    checks++; if (bus.out_xs3 !== 16'h4567) begin failures++; $display("FAIL ign_xs3 got=%h exp=4567", bus.out_xs3); end
    bus.in_start = 1'b1;
    bus.in_bcd   = 16'h5555;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_xs3 !== 16'h4567) begin failures++; $display("FAIL ign_hold cycle=%0d got=valid%b/%h exp=1/4567", c, bus.out_valid, bus.out_xs3); end
    end
    bus.in_start = 1'b0;
    do_ack();
  endtask

  task automatic test_start_ack();
    int n;
    start_job(16'h1111);
    wait_valid(n);
    bus.in_start = 1'b1;
    bus.in_bcd   = 16'h0001;
    bus.in_ack   = 1'b1;
    step();
    bus.in_ack = 1'b0;
    checks++; if (bus.out_busy !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL sa_ack_wins got=busy%b/valid%b exp=0/0", bus.out_busy, bus.out_valid); end
    step();
    bus.in_start = 1'b0;
    checks++; if (bus.out_busy !== 1'b1) begin failures++; $display("FAIL sa_held_start got=%b exp=1", bus.out_busy); end
    wait_valid(n);
    checks++; if (n !== 4) begin failures++; $display("FAIL sa_latency got=%0d exp=4", n); end
    checks++; if (bus.out_xs3 !== 16'h3334) begin failures++; $display("FAIL sa_xs3 got=%h exp=3334", bus.out_xs3); end
    do_ack();
  endtask

  task automatic test_reset_mid();
    int n;
    start_job(16'h1234);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_busy !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL rmid_ctrl got=busy%b/valid%b exp=0/0", bus.out_busy, bus.out_valid); end
    checks++; if (bus.out_xs3 !== 16'h0000 || bus.out_err !== 1'b0) begin failures++; $display("FAIL rmid_data got=%h/err%b exp=0000/0", bus.out_xs3, bus.out_err); end
    #3;
    rst_n = 1'b1;
    step();
    step();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_busy !== 1'b0) begin failures++; $display("FAIL rmid_abandoned got=busy%b/valid%b exp=0/0", bus.out_busy, bus.out_valid); end
    start_job(16'h8765);
    wait_valid(n);
    checks++; if (n !== 4) begin failures++; $display("FAIL rmid_latency got=%0d exp=4", n); end
    checks++; if (bus.out_xs3 !== 16'hBA98) begin failures++; $display("FAIL rmid_xs3 got=%h exp=ba98", bus.out_xs3); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL rmid_err got=%b exp=0", bus.out_err); end
    do_ack();
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b1;
    bus.in_start = 1'b0;
    bus.in_bcd   = 16'h0000;
    bus.in_ack   = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_invalid();
    test_patterns();
    test_ignore_start();
    test_start_ack();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
